// File: rtl/fft_corr_pkg.sv
// Shared types and constants for the correlation datapath front end.
package fft_corr_pkg;

    typedef enum logic [1:0] {IDLE, REF, SIG, BYP} seq_state_t;

    // Demux select encodings, shared with the downstream demultiplexer.
    localparam logic [1:0] SEL_REF = 2'b00;
    localparam logic [1:0] SEL_SIG = 2'b01;
    localparam logic [1:0] SEL_BYP = 2'b10;

    localparam int FRAME_LEN_DEFAULT = 1024;

endpackage

// File: rtl/frame_beat_counter.sv
// Counts handshaked beats modulo FRAME_LEN and flags the last beat of a frame.
// Kept standalone so the correlator output side can reuse it.
module frame_beat_counter
    import fft_corr_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_beat,
    output logic [$clog2(FRAME_LEN)-1:0] o_cnt,
    output logic                         o_last
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = i_beat && (r_cnt == LAST);

    // Beat position within the current frame; a clear wins over a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_beat)
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer ahead of the AXI-Stream demux: passes samples through,
// counts them into FFT frames and steers the demux select (one reference
// frame, then signal frames, or bypass) switching only on frame boundaries.
module fft_frame_sequencer
    import fft_corr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] indata_tdata,
    input  logic                  indata_tvalid,
    output logic                  indata_tready,
    output logic [DATA_WIDTH-1:0] outdata_tdata,
    output logic                  outdata_tvalid,
    input  logic                  outdata_tready,
    output logic [1:0]            demux_sel,
    input  logic                  start,
    input  logic                  bypass,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  num_frames,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  ref_loaded
);

    seq_state_t                   r_state;
    logic [1:0]                   r_sel;
    logic [CNT_WIDTH-1:0]         r_num;
    logic [CNT_WIDTH-1:0]         r_frame_cnt;
    logic                         r_stop_pending;
    logic                         r_frame_done;
    logic                         r_ref_loaded;

    logic                         w_active;
    logic                         w_beat;
    logic                         w_last;
    logic                         w_start;
    logic                         w_stop_now;
    logic                         w_sat;
    logic                         w_term;
    logic [CNT_WIDTH:0]           w_frame_inc;
    logic [$clog2(FRAME_LEN)-1:0] w_beat_cnt;

    // Zero-latency pass-through, gated while idle. tvalid never looks at tready.
    assign w_active       = (r_state != IDLE);
    assign outdata_tdata  = indata_tdata;
    assign outdata_tvalid = indata_tvalid & w_active;
    assign indata_tready  = outdata_tready & w_active;
    assign w_beat         = outdata_tvalid & outdata_tready;

    assign w_start     = start & ~w_active;
    assign w_stop_now  = r_stop_pending | stop;
    assign w_sat       = &r_frame_cnt;
    // Extra MSB keeps a saturated counter from aliasing onto num_frames.
    assign w_frame_inc = {1'b0, r_frame_cnt} + 1'b1;
    assign w_term      = (r_num != '0) && !w_frame_inc[CNT_WIDTH] &&
                         (w_frame_inc[CNT_WIDTH-1:0] == r_num);

    assign demux_sel  = r_sel;
    assign busy       = w_active;
    assign frame_done = r_frame_done;
    assign ref_loaded = r_ref_loaded;

    frame_beat_counter #(.FRAME_LEN(FRAME_LEN)) u_beat_cnt (
        .clk    (aclk),
        .rst_n  (aresetn),
        .i_clr  (w_start),
        .i_beat (w_beat),
        .o_cnt  (w_beat_cnt),
        .o_last (w_last)
    );

    // Run control: state, select, frame accounting and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= IDLE;
            r_sel          <= SEL_REF;
            r_num          <= '0;
            r_frame_cnt    <= '0;
            r_stop_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            r_ref_loaded   <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_active && stop)
                r_stop_pending <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num          <= num_frames;
                        r_frame_cnt    <= '0;
                        r_stop_pending <= 1'b0;
                        r_ref_loaded   <= 1'b0;
                        r_state        <= bypass ? BYP : REF;
                        r_sel          <= bypass ? SEL_BYP : SEL_REF;
                    end
                end
                REF: begin
                    if (w_last) begin
                        r_ref_loaded <= 1'b1;
                        if (w_stop_now) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= SIG;
                            r_sel   <= SEL_SIG;
                        end
                    end
                end
                SIG, BYP: begin
                    if (w_last) begin
                        if (!w_sat)
                            r_frame_cnt <= w_frame_inc[CNT_WIDTH-1:0];
                        if (w_stop_now || w_term)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with FRAME_LEN = 8.
module tb_fft_frame_sequencer;

    localparam int DW = 32;
    localparam int FL = 8;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] indata_tdata = 32'h100;
    logic          indata_tvalid = 1'b1;
    logic          indata_tready;
    logic [DW-1:0] outdata_tdata;
    logic          outdata_tvalid;
    logic          outdata_tready = 1'b1;
    logic [1:0]    demux_sel;
    logic          start = 1'b0;
    logic          bypass = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] num_frames = '0;
    logic          busy;
    logic          frame_done;
    logic          ref_loaded;

    int checks = 0;
    int failures = 0;

    int q_sel[$];
    int q_dat[$];
    int q_cyc[$];
    int nbeats, fd_cnt, cyc, sel_bad, base;
    logic [1:0] prev_sel = 2'b00;
    logic prev_ok = 1'b0;
    logic rnd_rdy = 1'b0;

    always #5 aclk = ~aclk;

    fft_frame_sequencer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .indata_tdata   (indata_tdata),
        .indata_tvalid  (indata_tvalid),
        .indata_tready  (indata_tready),
        .outdata_tdata  (outdata_tdata),
        .outdata_tvalid (outdata_tvalid),
        .outdata_tready (outdata_tready),
        .demux_sel      (demux_sel),
        .start          (start),
        .bypass         (bypass),
        .stop           (stop),
        .num_frames     (num_frames),
        .busy           (busy),
        .frame_done     (frame_done),
        .ref_loaded     (ref_loaded)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: observe at negedge, advance stimulus just after posedge.
    task automatic step();
        logic bt;
        @(negedge aclk);
        bt = outdata_tvalid && outdata_tready;
        if (demux_sel != prev_sel && !prev_ok) sel_bad++;
        prev_ok  = (start && !busy) || (bt && ((nbeats + 1) % FL == 0));
        prev_sel = demux_sel;
        if (frame_done) fd_cnt++;
        if (bt) begin
            q_sel.push_back(int'(demux_sel));
            q_dat.push_back(int'(outdata_tdata));
            q_cyc.push_back(cyc);
            nbeats++;
        end
        cyc++;
        @(posedge aclk);
        #1;
        if (bt) indata_tdata = indata_tdata + 1;
        start = 1'b0;
        stop  = 1'b0;
        outdata_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Start a run and step until it returns to idle (or abort_at beats).
    task automatic run(input logic byp, input int nf, input int stop_at,
                       input int restart_at, input logic with_stop,
                       input int abort_at, input string tag);
        logic stop_done = 1'b0;
        logic rs_done = 1'b0;
        logic finished = 1'b0;
        q_sel.delete(); q_dat.delete(); q_cyc.delete();
        nbeats = 0; fd_cnt = 0; cyc = 0; sel_bad = 0;
        base = int'(indata_tdata);
        bypass = byp; num_frames = CW'(nf); start = 1'b1; stop = with_stop;
        step();
        for (int n = 0; n < 400; n++) begin
            if (!stop_done && nbeats == stop_at) begin stop = 1'b1; stop_done = 1'b1; end
            if (!rs_done && nbeats == restart_at) begin
                start = 1'b1; bypass = 1'b1; num_frames = CW'(1); rs_done = 1'b1;
            end
            step();
            if (abort_at >= 0 && nbeats == abort_at) return;
            if (!busy) begin finished = 1'b1; break; end
        end
        chk({tag, "_finished"}, int'(finished), 1);
        outdata_tready = 1'b1;
        step();
    endtask

    task automatic chk_sel(input string tag, input int lo, input int hi, input int exp);
        int bad = 0;
        for (int i = lo; i <= hi && i < q_sel.size(); i++)
            if (q_sel[i] != exp) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_order(input string tag);
        int bad = 0;
        for (int i = 0; i < q_dat.size(); i++)
            if (q_dat[i] != base + i) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_sel", int'(demux_sel), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_refl", int'(ref_loaded), 0);
        chk("rst_ready", int'(indata_tready), 0);
        chk("rst_valid", int'(outdata_tvalid), 0);
        #20 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("idle_gated", int'(outdata_tvalid), 0);

        // 1: ref + 2 signal frames, continuous flow
        run(1'b0, 2, -1, -1, 1'b0, -1, "t1");
        chk("t1_beats", nbeats, 24);
        chk_sel("t1_sel_ref", 0, 7, 0);
        chk_sel("t1_sel_sig", 8, 23, 1);
        chk("t1_nobubble", q_cyc[23] - q_cyc[0], 23);
        chk_order("t1_order");
        chk("t1_fd", fd_cnt, 3);
        chk("t1_refl", int'(ref_loaded), 1);
        chk("t1_busy", int'(busy), 0);
        chk("t1_gated", int'(indata_tready), 0);

        // 2: same run under random backpressure
        rnd_rdy = 1'b1;
        run(1'b0, 2, -1, -1, 1'b0, -1, "t2");
        rnd_rdy = 1'b0;
        chk("t2_beats", nbeats, 24);
        chk_order("t2_order");
        chk_sel("t2_sel_ref", 0, 7, 0);
        chk_sel("t2_sel_sig", 8, 23, 1);
        chk("t2_sel_switch", sel_bad, 0);
        chk("t2_fd", fd_cnt, 3);

        // 3: continuous bypass, stop mid second frame
        run(1'b1, 0, 13, -1, 1'b0, -1, "t3");
        chk("t3_beats", nbeats, 16);
        chk_sel("t3_sel", 0, 15, 2);
        chk("t3_busy", int'(busy), 0);
        chk("t3_gated", int'(indata_tready), 0);
        chk("t3_fd", fd_cnt, 2);

        // 4: stop during the reference frame
        run(1'b0, 2, 3, -1, 1'b0, -1, "t4");
        chk("t4_beats", nbeats, 8);
        chk_sel("t4_sel", 0, 7, 0);
        chk("t4_sel_end", int'(demux_sel), 0);
        chk("t4_refl", int'(ref_loaded), 1);

        // 5: reset at beat 5 of the signal frame
        run(1'b0, 2, -1, -1, 1'b0, 13, "t5");
        chk("t5_pre_busy", int'(busy), 1);
        aresetn = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_sel", int'(demux_sel), 0);
        chk("t5_ready", int'(indata_tready), 0);
        chk("t5_refl", int'(ref_loaded), 0);
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        prev_sel = 2'b00; prev_ok = 1'b0;
        @(posedge aclk); #1;
        run(1'b0, 1, -1, -1, 1'b0, -1, "t5b");
        chk("t5b_beats", nbeats, 16);
        chk_sel("t5b_sel_ref", 0, 7, 0);
        chk_sel("t5b_sel_sig", 8, 15, 1);
        chk_order("t5b_order");

        // 6a: start while active is ignored
        run(1'b0, 3, -1, 10, 1'b0, -1, "t6a");
        chk("t6a_beats", nbeats, 32);
        chk_sel("t6a_sel_sig", 8, 31, 1);
        chk("t6a_fd", fd_cnt, 4);

        // 6b: start and stop together in idle: run is not stopped
        run(1'b0, 1, -1, -1, 1'b1, -1, "t6b");
        chk("t6b_beats", nbeats, 16);
        chk_sel("t6b_sel_sig", 8, 15, 1);
        chk("t6b_refl", int'(ref_loaded), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sits directly upstream of the AXI-Stream demultiplexer in the correlation datapath.
- Forwards the input sample stream unchanged and counts handshaked beats into FFT frames.
- Drives the demux select: one reference frame goes to the reference-FFT port, then signal frames go to the signal-FFT port, or all frames go to the bypass port.
- Gates the stream while idle and switches the select only on frame boundaries.

Parameters:
- DATA_WIDTH, 32, tdata width of indata/outdata.
- FRAME_LEN, 1024, beats per frame (FFT size); power of two, at least 4.
- CNT_WIDTH, 16, width of the frame counter and of num_frames.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- indata  AXIS_intf.Slave  DATA_WIDTH  source sample stream.
- outdata  AXIS_intf.Master  DATA_WIDTH  stream to the demux indata.
- demux_sel  out  2  demux select: 00 = ref, 01 = signal, 10 = bypass; 11 never driven.
- start  in  1  single-cycle start request.
- bypass  in  1  sampled with start; 1 selects bypass mode.
- stop  in  1  single-cycle stop request; takes effect at the next frame boundary.
- num_frames  in  CNT_WIDTH  signal/bypass frames per run, sampled with start; 0 = run until stop.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse, the cycle after any frame's last beat.
- ref_loaded  out  1  set when the reference frame completes; cleared on an accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE, beat_cnt 0, frame_cnt 0, demux_sel 00, stop_pending 0, busy/frame_done/ref_loaded 0.
- Datapath is combinational pass-through with zero latency:
  - outdata.tdata = indata.tdata.
  - outdata.tvalid = indata.tvalid & active.
  - indata.tready = outdata.tready & active.
  - active = (state != IDLE).
- beat = outdata.tvalid & outdata.tready.
- States: IDLE, REF, SIG, BYP. demux_sel is registered: REF = 00, SIG = 01, BYP = 10. In IDLE it holds its last value.
- IDLE:
  - start=1 latches num_frames and clears frame_cnt, beat_cnt, stop_pending and ref_loaded.
  - Next state is REF if bypass=0, else BYP. demux_sel updates on that same edge.
- beat_cnt increments on each beat and wraps to 0 on beat FRAME_LEN-1 (the last beat).
- On the last beat, frame_done pulses the following cycle.
- REF last beat: ref_loaded <= 1. Next state is IDLE if stop_pending or stop is high that cycle, else SIG.
- SIG/BYP last beat: frame_cnt++. Next state is IDLE if stop_pending, stop this cycle, or (num_frames != 0 and frame_cnt+1 == num_frames); otherwise hold state.
- Select switch is bubble-free: the beat after the last beat of REF may occur the very next cycle and is routed with sel 01.
- stop while active sets stop_pending. Mid-frame, the frame always completes; frames are never truncated.
- stop in IDLE is ignored. start while active is ignored. start and stop together in IDLE: start accepted, stop ignored.
- frame_cnt saturates at all-ones in continuous mode and does not wrap into a false terminal match.
- tvalid/tdata stable under backpressure follow from the pass-through; outdata.tvalid must not depend on outdata.tready.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, stream gated on the first cycle of reset.

Decomposition:
- Shared package fft_corr_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, REF, SIG, BYP}.
  - Constants SEL_REF = 2'b00, SEL_SIG = 2'b01, SEL_BYP = 2'b10 (also used by the demux).
  - Constant FRAME_LEN_DEFAULT.
- Sub-module frame_beat_counter: counts beats modulo FRAME_LEN and outputs a last_beat strobe. Reusable at the correlator output.

Test Plan:
- Reset, then start=1, bypass=0, num_frames=2, FRAME_LEN=8, continuous valid/ready -> sel 00 for beats 0-7, 01 for beats 8-23 with no bubble, IDLE after beat 23; frame_done pulses 3 times; ref_loaded=1.
- Random tready at 50% backpressure, same run -> exactly 24 beats transferred, data order preserved, sel changes only on the cycle after a last beat.
- start with bypass=1, num_frames=0; stop at beat 13 -> sel 10 throughout, stops after beat 15, busy falls, indata.tready=0 afterwards.
- stop asserted during the REF frame -> returns to IDLE after beat 7, sel never becomes 01, ref_loaded=1.
- aresetn dropped at beat 5 of a SIG frame -> busy=0, sel 00 and tready 0 immediately; a new start gives a full 8-beat REF frame.
- start during SIG, and start+stop together in IDLE -> the first is ignored; the second starts a run that is not stopped.
